// File: rtl/gcm_aes_decrypt_pkg.sv
// Types, constants and helpers shared by the GCM encryptor and decryptor.
package gcm_pkg;

   typedef logic [0:127] block_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HKEY,
      ST_EJ0,
      ST_AAD,
      ST_CT_WAIT,
      ST_CT_PROC,
      ST_PT_OUT,
      ST_LEN,
      ST_CHECK,
      ST_DONE
   } gcm_dec_state_e;

   localparam block_t      GCM_R      = {8'hE1, 120'h0};
   localparam logic [31:0] GCM_J0_LSB = 32'h1;

   // Increment only the low 32-bit word; the IV part is carried through untouched.
   function automatic block_t inc32(input block_t b);
      logic [31:0] lo;
      lo = b[96:127] + 32'h1;
      return {b[0:95], lo};
   endfunction

endpackage

// File: rtl/gcm_aes_decrypt_if.sv
// Control, AES engine, ciphertext and plaintext signals of the GCM decryptor.
interface gcm_aes_decrypt_if;
   import gcm_pkg::*;

   logic        new_instance;
   logic [0:95] iv;
   block_t      aad;
   logic        aad_en;
   logic        ct_empty;
   block_t      tag;
   logic        aes_req;
   block_t      aes_block;
   logic        aes_ack;
   block_t      aes_result;
   logic        ct_valid;
   logic        ct_ready;
   block_t      ct_data;
   logic        ct_last;
   logic        pt_valid;
   block_t      pt_data;
   logic        pt_ready;
   logic        done;
   logic        tag_ok;

   modport master (
      output new_instance, iv, aad, aad_en, ct_empty, tag,
      output aes_ack, aes_result, ct_valid, ct_data, ct_last, pt_ready,
      input  aes_req, aes_block, ct_ready, pt_valid, pt_data, done, tag_ok
   );

   modport slave (
      input  new_instance, iv, aad, aad_en, ct_empty, tag,
      input  aes_ack, aes_result, ct_valid, ct_data, ct_last, pt_ready,
      output aes_req, aes_block, ct_ready, pt_valid, pt_data, done, tag_ok
   );

endinterface

// File: rtl/gcm_aes_decrypt_gf128_mul.sv
// Bit-serial GF(2^128) multiplier in GCM bit order: 128 busy cycles, then a one-cycle done.
module gf128_mul
   import gcm_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   start,
   input  block_t a,
   input  block_t b,
   output logic   done,
   output block_t result
);

   block_t     z;
   block_t     v;
   block_t     a_sr;
   logic [6:0] cnt;
   logic       busy;

   assign result = z;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z    <= '0;
         v    <= '0;
         a_sr <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            z    <= '0;
            v    <= b;
            a_sr <= a;
            cnt  <= '0;
            busy <= 1'b1;
         end else if (busy) begin
            // a_sr[0] is the x^0 coefficient of the multiplier still to be consumed
            z    <= z ^ (a_sr[0] ? v : '0);
            v    <= (v >> 1) ^ (v[127] ? GCM_R : '0);
            a_sr <= a_sr << 1;
            cnt  <= cnt + 7'd1;
            if (cnt == 7'd127) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/gcm_aes_decrypt.sv
// Streaming AES-GCM decrypt-and-verify; block encryptions go to a shared AES engine.
//   state   | meaning
//   IDLE    | waiting for new_instance
//   HKEY    | H = AES(0)
//   EJ0     | EkJ0 = AES(IV||1)
//   AAD     | X = (X^A)*H
//   CT_WAIT | ct_ready high, waiting for a ciphertext block
//   CT_PROC | keystream request and GHASH multiply in flight
//   PT_OUT  | plaintext presented; waits for consumer and multiply
//   LEN     | X = (X^len)*H
//   CHECK   | tag compare
//   DONE    | verdict held
module gcm_aes_decrypt
   import gcm_pkg::*;
#(
   parameter int LEN_W = 32
) (
   input logic clk,
   input logic rst,
   gcm_aes_decrypt_if.slave bus
);

   gcm_dec_state_e state;
   block_t         h;
   block_t         ekj0;
   block_t         x;
   block_t         ctr;
   block_t         ct_r;
   block_t         aad_r;
   block_t         tag_r;
   logic           aad_en_r;
   logic           ct_empty_r;
   logic           last_r;
   logic [LEN_W-1:0] blocks;

   logic   mul_start;
   logic   mul_pend;
   logic   mul_done;
   block_t mul_a;
   block_t mul_res;

   logic   aes_req;
   block_t aes_block;
   logic   ct_ready;
   logic   pt_valid;
   block_t pt_data;
   logic   done;
   logic   tag_ok;

   logic [63:0] ct_bits;
   block_t      len_blk;

   assign ct_bits = 64'(blocks) << 7;
   assign len_blk = {(aad_en_r ? 64'd128 : 64'd0), ct_bits};

   assign bus.aes_req   = aes_req;
   assign bus.aes_block = aes_block;
   assign bus.ct_ready  = ct_ready;
   assign bus.pt_valid  = pt_valid;
   assign bus.pt_data   = pt_data;
   assign bus.done      = done;
   assign bus.tag_ok    = tag_ok;

   gf128_mul u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start),
      .a      (mul_a),
      .b      (h),
      .done   (mul_done),
      .result (mul_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         h          <= '0;
         ekj0       <= '0;
         x          <= '0;
         ctr        <= '0;
         ct_r       <= '0;
         aad_r      <= '0;
         tag_r      <= '0;
         aad_en_r   <= 1'b0;
         ct_empty_r <= 1'b0;
         last_r     <= 1'b0;
         blocks     <= '0;
         mul_start  <= 1'b0;
         mul_pend   <= 1'b0;
         mul_a      <= '0;
         aes_req    <= 1'b0;
         aes_block  <= '0;
         ct_ready   <= 1'b0;
         pt_valid   <= 1'b0;
         pt_data    <= '0;
         done       <= 1'b0;
         tag_ok     <= 1'b0;
      end else begin
         mul_start <= 1'b0;
         if (mul_done) begin
            x        <= mul_res;
            mul_pend <= 1'b0;
         end
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.new_instance) begin
                  ctr        <= inc32({bus.iv, GCM_J0_LSB});
                  aad_r      <= bus.aad;
                  aad_en_r   <= bus.aad_en;
                  ct_empty_r <= bus.ct_empty;
                  tag_r      <= bus.tag;
                  last_r     <= 1'b0;
                  x          <= '0;
                  blocks     <= '0;
                  done       <= 1'b0;
                  tag_ok     <= 1'b0;
                  aes_req    <= 1'b1;
                  aes_block  <= '0;
                  state      <= ST_HKEY;
               end
            end
            ST_HKEY: begin
               if (bus.aes_ack) begin
                  h       <= bus.aes_result;
                  aes_req <= 1'b0;
                  state   <= ST_EJ0;
               end
            end
            ST_EJ0: begin
               if (bus.aes_ack) begin
                  ekj0    <= bus.aes_result;
                  aes_req <= 1'b0;
                  if (aad_en_r) begin
                     mul_a     <= x ^ aad_r;
                     mul_start <= 1'b1;
                     mul_pend  <= 1'b1;
                     state     <= ST_AAD;
                  end else begin
                     ct_ready <= !ct_empty_r;
                     state    <= ST_CT_WAIT;
                  end
               end else if (!aes_req) begin
                  aes_req   <= 1'b1;
                  aes_block <= {ctr[0:95], GCM_J0_LSB};
               end
            end
            ST_AAD: begin
               if (!mul_pend) begin
                  ct_ready <= !ct_empty_r;
                  state    <= ST_CT_WAIT;
               end
            end
            ST_CT_WAIT: begin
               if (ct_empty_r) begin
                  mul_a     <= x ^ len_blk;
                  mul_start <= 1'b1;
                  mul_pend  <= 1'b1;
                  state     <= ST_LEN;
               end else if (bus.ct_valid && ct_ready) begin
                  ct_ready  <= 1'b0;
                  ct_r      <= bus.ct_data;
                  last_r    <= bus.ct_last;
                  mul_a     <= x ^ bus.ct_data;
                  mul_start <= 1'b1;
                  mul_pend  <= 1'b1;
                  aes_req   <= 1'b1;
                  aes_block <= ctr;
                  ctr       <= inc32(ctr);
                  if (blocks != '1)
                     blocks <= blocks + LEN_W'(1);
                  state     <= ST_CT_PROC;
               end
            end
            ST_CT_PROC: begin
               if (bus.aes_ack) begin
                  aes_req  <= 1'b0;
                  pt_data  <= ct_r ^ bus.aes_result;
                  pt_valid <= 1'b1;
                  state    <= ST_PT_OUT;
               end
            end
            ST_PT_OUT: begin
               if (pt_valid && bus.pt_ready)
                  pt_valid <= 1'b0;
               // X is only settled once mul_pend has dropped, so the next operand sees it
               if (!pt_valid && !mul_pend) begin
                  if (last_r) begin
                     mul_a     <= x ^ len_blk;
                     mul_start <= 1'b1;
                     mul_pend  <= 1'b1;
                     state     <= ST_LEN;
                  end else begin
                     ct_ready <= 1'b1;
                     state    <= ST_CT_WAIT;
                  end
               end
            end
            ST_LEN: begin
               if (!mul_pend)
                  state <= ST_CHECK;
            end
            ST_CHECK: begin
               tag_ok <= ((x ^ ekj0) == tag_r);
               done   <= 1'b1;
               state  <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcm_aes_decrypt.sv
// Directed bench for gcm_aes_decrypt: NIST TC1/TC2, round trips, backpressure, reset abort.
module tb_gcm_aes_decrypt;
   import gcm_pkg::*;

   typedef struct {
      logic [0:95]     iv;
      block_t          aad;
      bit              aad_en;
      bit              ct_empty;
      int              n;
      block_t [0:2]    ct;
      block_t [0:2]    pt;
      block_t          tag;
      bit              ok;
      int              lat;
   } vec_t;

   logic clk;
   logic rst;
   gcm_aes_decrypt_if bus();

   gcm_aes_decrypt #(.LEN_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int     n_chk  = 0;
   int     n_fail = 0;
   int     eng_lat = 2;
   block_t req_q[$];
   vec_t   vecs[6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Stand-in for the AES-128 engine: exact key-0 values for the NIST points, a fixed mix elsewhere.
   function automatic block_t eng(input block_t b);
      case (b)
         128'h0:  return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
         128'h1:  return 128'h58e2fccefa7e3061367f1d57a4e7455a;
         128'h2:  return 128'h0388dace60b6a392f328c2b971b2fe78;
         default: return {b[29:127], b[0:28]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0
                         ^ {b[0:63] + 64'h9e3779b97f4a7c15, 64'h0};
      endcase
   endfunction

   function automatic block_t gmul(input block_t a, input block_t b);
      block_t z = '0;
      block_t v = b;
      for (int i = 0; i < 128; i++) begin
         if (a[i]) z = z ^ v;
         v = v[127] ? ((v >> 1) ^ GCM_R) : (v >> 1);
      end
      return z;
   endfunction

   // Reference encryptor: fills ct and tag from pt.
   function automatic vec_t seal(input vec_t v);
      block_t hk, x, ctr, lenb;
      hk  = eng('0);
      x   = '0;
      if (v.aad_en) x = gmul(x ^ v.aad, hk);
      ctr = {v.iv, 32'h2};
      for (int i = 0; i < v.n; i++) begin
         v.ct[i] = v.pt[i] ^ eng(ctr);
         x = gmul(x ^ v.ct[i], hk);
         ctr[96:127] = ctr[96:127] + 32'h1;
      end
      lenb  = {(v.aad_en ? 64'd128 : 64'd0), 64'(v.n) * 64'd128};
      v.tag = gmul(x ^ lenb, hk) ^ eng({v.iv, 32'h1});
      return v;
   endfunction

   function automatic vec_t mk(input logic [0:95] iv, input block_t aad, input bit aad_en,
                               input int n, input block_t tag, input bit ok, input int lat);
      vec_t v;
      v.iv = iv; v.aad = aad; v.aad_en = aad_en; v.ct_empty = (n == 0); v.n = n;
      v.ct = '0; v.pt = '0; v.tag = tag; v.ok = ok; v.lat = lat;
      return v;
   endfunction

   initial begin
      block_t blk;
      bus.aes_ack    = 1'b0;
      bus.aes_result = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.aes_ack = 1'b0;
         end else if (bus.aes_ack) begin
            bus.aes_ack = 1'b0;
         end else if (bus.aes_req) begin
            blk = bus.aes_block;
            req_q.push_back(blk);
            repeat (eng_lat - 1) @(negedge clk);
            if (!rst) begin
               bus.aes_ack    = 1'b1;
               bus.aes_result = eng(blk);
            end
         end
      end
   end

   task automatic run_vec(input vec_t v, input int abort_blk, output bit aborted);
      int sent = 0, got = 0, hold = 0, hold_err = 0, abort_cnt = 0;
      bit hs = 0;
      bit finished = 0;
      block_t held = '0;
      aborted = 0;
      eng_lat = v.lat;
      req_q.delete();
      bus.iv = v.iv; bus.aad = v.aad; bus.aad_en = v.aad_en;
      bus.ct_empty = v.ct_empty; bus.tag = v.tag;
      bus.new_instance = 1'b1;
      @(negedge clk);
      bus.new_instance = 1'b0;
      for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
         if (hs) sent++;
         if (abort_blk > 0 && sent == abort_blk) begin
            abort_cnt++;
            if (abort_cnt == 20) begin
               aborted = 1;
               return;
            end
         end
         if (bus.done) begin
            finished = 1;
         end else begin
            bus.ct_valid = 1'b1;
            bus.ct_data  = (sent < v.n) ? v.ct[sent] : '1;
            bus.ct_last  = (sent >= v.n - 1);
            hs = bus.ct_valid && bus.ct_ready;
            if (bus.pt_valid) begin
               if (hold == 0) held = bus.pt_data;
               if (hold < 5) begin
                  bus.pt_ready = 1'b0;
                  if (bus.pt_data !== held || bus.ct_ready !== 1'b0) hold_err++;
                  hold++;
               end else begin
                  bus.pt_ready = 1'b1;
                  if (got < v.n) chk($sformatf("pt_blk%0d", got), bus.pt_data, v.pt[got]);
                  got++;
                  hold = 0;
               end
            end else begin
               bus.pt_ready = 1'b0;
            end
            @(negedge clk);
         end
      end
      bus.ct_valid = 1'b0;
      bus.pt_ready = 1'b0;
      chk("done", bus.done, 1);
      chk("tag_ok", bus.tag_ok, v.ok);
      chk("pt_count", got, v.n);
      chk("ct_accepted", sent, v.n);
      chk("pt_hold_stable", hold_err, 0);
      chk("ct_ready_after_done", bus.ct_ready, 0);
      if (req_q.size() == 2 + v.n) begin
         chk("req_hkey", req_q[0], '0);
         chk("req_j0", req_q[1], {v.iv, 32'h1});
         for (int i = 0; i < v.n; i++)
            chk($sformatf("req_ctr%0d", i), req_q[2 + i], {v.iv, 32'(2 + i)});
      end else begin
         chk("req_count", req_q.size(), 2 + v.n);
      end
   endtask

   initial begin
      bit     ab;
      block_t b0;
      rst = 1'b1;
      bus.new_instance = 0; bus.iv = '0; bus.aad = '0; bus.aad_en = 0; bus.ct_empty = 0;
      bus.tag = '0; bus.ct_valid = 0; bus.ct_data = '0; bus.ct_last = 0; bus.pt_ready = 0;
      repeat (3) @(negedge clk);
      chk("rst_ctrl_outputs", {bus.aes_req, bus.ct_ready, bus.pt_valid, bus.done, bus.tag_ok}, 0);
      chk("rst_aes_block", bus.aes_block, '0);
      chk("rst_pt_data", bus.pt_data, '0);
      rst = 1'b0;
      @(negedge clk);

      b0 = {96'h0123456789abcdef01234567, 32'hFFFFFFFE};
      chk("inc32_fe", inc32(b0), {96'h0123456789abcdef01234567, 32'hFFFFFFFF});
      chk("inc32_wrap", inc32(inc32(b0)), {96'h0123456789abcdef01234567, 32'h00000000});

      vecs[0] = mk('0, '0, 0, 0, 128'h58e2fccefa7e3061367f1d57a4e7455a, 1, 2);
      vecs[1] = mk('0, '0, 0, 1, 128'hab6e47d42cec13bdf53a67b21257bddf, 1, 1);
      vecs[1].ct[0] = 128'h0388dace60b6a392f328c2b971b2fe78;
      vecs[2] = vecs[1];
      vecs[2].tag = 128'hab6e47d42cec13bdf53a67b21257bdde;
      vecs[2].ok  = 0;
      vecs[3] = mk(96'hcafebabefacedbaddecaf888, 128'hfeedfacedeadbeeffeedfacedeadbeef, 1, 3, '0, 1, 4);
      vecs[3].pt[0] = 128'hd9313225f88406e5a55909c5aff5269a;
      vecs[3].pt[1] = 128'h86a7a9531534f7da2e4c303d8a318a72;
      vecs[3].pt[2] = 128'h1c3c0c95956809532fcf0e2449a6b525;
      vecs[3] = seal(vecs[3]);
      vecs[4] = mk(96'h0123456789abcdef01234567, '0, 0, 2, '0, 1, 140);
      vecs[4].pt[0] = 128'h00112233445566778899aabbccddeeff;
      vecs[4].pt[1] = 128'hffeeddccbbaa99887766554433221100;
      vecs[4] = seal(vecs[4]);
      vecs[5] = vecs[3];
      vecs[5].aad[0] = ~vecs[5].aad[0];
      vecs[5].ok = 0;

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], 0, ab);
         @(negedge clk);
      end

      // Reset while block 2's GHASH multiply is in flight
      run_vec(vecs[3], 2, ab);
      chk("abort_point_reached", ab, 1);
      bus.ct_valid = 1'b0;
      bus.pt_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_ctrl_outputs", {bus.aes_req, bus.ct_ready, bus.pt_valid, bus.done, bus.tag_ok}, 0);
      chk("midrst_aes_block", bus.aes_block, '0);
      chk("midrst_pt_data", bus.pt_data, '0);
      @(negedge clk);
      chk("midrst_state", dut.state, ST_IDLE);
      chk("midrst_regs", dut.x | dut.h | dut.ekj0, '0);
      rst = 1'b0;
      @(negedge clk);
      run_vec(vecs[1], 0, ab);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
